// File: rtl/sdram_responder.sv
// sdram_responder: device-side model of an SDR SDRAM (MT48LC16M16 style command set).
// Decodes the controller's command bus, keeps per-bank open/row/tRCD state, services
// reads and writes against a small on-chip word array and records protocol violations
// in sticky error flags. The word array is deliberately not reset so data survives init.
module sdram_responder #(
  parameter int ROW_W = 5,
  parameter int COL_W = 5,
  parameter int TRCD  = 2
) (
  input  logic        clk,
  input  logic        init,
  input  logic        sd_cke,
  input  logic        sd_ncs,
  input  logic        sd_nras,
  input  logic        sd_ncas,
  input  logic        sd_nwe,
  input  logic [1:0]  sd_ba,
  input  logic [12:0] sd_a,
  input  logic        sd_dqml,
  input  logic        sd_dqmh,
  input  logic [15:0] sd_dq_in,
  output logic [15:0] sd_dq_out,
  output logic        sd_dq_oe,
  output logic [12:0] mode_reg,
  output logic        mode_valid,
  output logic [15:0] refresh_cnt,
  output logic [5:0]  err
);

  localparam int AW    = 2 + ROW_W + COL_W;
  localparam int DEPTH = 2 ** AW;
  localparam int RCD_W = (TRCD > 1) ? $clog2(TRCD) : 1;
  localparam logic [RCD_W-1:0] RCD_LOAD = RCD_W'(TRCD - 1);
  localparam logic [RCD_W-1:0] RCD_ONE  = RCD_W'(1);
  localparam logic [RCD_W-1:0] RCD_ZERO = RCD_W'(0);

  typedef enum logic [2:0] {
    CMD_LOAD_MODE  = 3'b000,
    CMD_REFRESH    = 3'b001,
    CMD_PRECHARGE  = 3'b010,
    CMD_ACTIVE     = 3'b011,
    CMD_WRITE      = 3'b100,
    CMD_READ       = 3'b101,
    CMD_BURST_TERM = 3'b110,
    CMD_NOP        = 3'b111
  } cmd_t;

  cmd_t             cmd;
  logic [3:0]       bank_open;
  logic [ROW_W-1:0] bank_row [4];
  logic [RCD_W-1:0] bank_rcd [4];
  logic [15:0]      mem [DEPTH];

  logic             cur_open;
  logic [ROW_W-1:0] cur_row;
  logic [AW-1:0]    idx;
  logic             any_open;
  logic             rd_pending;
  logic             do_read;
  logic             do_write;
  logic             mode_legal;
  logic             mode_blocked;
  logic             cl3;
  logic [15:0]      rd_word;
  logic [15:0]      rd_data;
  logic [5:0]       err_set;

  // Read return pipeline: stage 1 holds the word captured with the READ, stage 2 the
  // extra cycle of latency needed for CAS latency 3.
  logic             pipe1_valid;
  logic             pipe1_cl3;
  logic [15:0]      pipe1_data;
  logic             pipe2_valid;
  logic [15:0]      pipe2_data;

  // Command decode: deselected or clock-disabled cycles behave as NOP.
  always_comb begin
    if (sd_cke && !sd_ncs) begin
      cmd = cmd_t'({sd_nras, sd_ncas, sd_nwe});
    end else begin
      cmd = CMD_NOP;
    end
  end

  assign cur_open     = bank_open[sd_ba];
  assign cur_row      = bank_row[sd_ba];
  assign idx          = {sd_ba, cur_row, sd_a[COL_W-1:0]};
  assign any_open     = |bank_open;
  // A read is "pending" from the cycle after it is sampled until its data is registered.
  assign rd_pending   = pipe1_valid | pipe2_valid;
  assign do_read      = (cmd == CMD_READ) && cur_open;
  assign do_write     = (cmd == CMD_WRITE) && cur_open;
  assign mode_legal   = ((sd_a[6:4] == 3'd2) || (sd_a[6:4] == 3'd3)) && (sd_a[2:0] == 3'd0);
  assign mode_blocked = any_open | rd_pending;
  assign cl3          = (mode_reg[6:4] == 3'd3);
  assign rd_word      = mem[idx];
  assign rd_data      = {(sd_dqmh ? 8'h00 : rd_word[15:8]), (sd_dqml ? 8'h00 : rd_word[7:0])};

  // Violation detection for the command sampled this cycle.
  always_comb begin
    err_set = 6'b000000;
    case (cmd)
      CMD_ACTIVE: begin
        err_set[0] = cur_open;
      end
      CMD_READ: begin
        err_set[1] = !cur_open;
        err_set[2] = cur_open && (bank_rcd[sd_ba] != RCD_ZERO);
        err_set[5] = !mode_valid;
      end
      CMD_WRITE: begin
        err_set[1] = !cur_open;
        err_set[2] = cur_open && (bank_rcd[sd_ba] != RCD_ZERO);
        err_set[3] = rd_pending;
        err_set[5] = !mode_valid;
      end
      CMD_REFRESH: begin
        err_set[4] = any_open;
      end
      CMD_LOAD_MODE: begin
        err_set[4] = mode_blocked;
        err_set[5] = !mode_blocked && !mode_legal;
      end
      default: begin
        err_set = 6'b000000;
      end
    endcase
  end

  // Bank bookkeeping: open flags, latched rows and tRCD countdown.
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      bank_open <= 4'b0000;
      for (int b = 0; b < 4; b++) begin
        bank_row[b] <= {ROW_W{1'b0}};
        bank_rcd[b] <= RCD_ZERO;
      end
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (bank_rcd[b] != RCD_ZERO) begin
          bank_rcd[b] <= bank_rcd[b] - RCD_ONE;
        end
      end
      case (cmd)
        CMD_ACTIVE: begin
          if (!cur_open) begin
            bank_open[sd_ba] <= 1'b1;
            bank_row[sd_ba]  <= sd_a[ROW_W-1:0];
            bank_rcd[sd_ba]  <= RCD_LOAD;
          end
        end
        CMD_READ, CMD_WRITE: begin
          // Auto-precharge closes the bank once the access has been taken.
          if (cur_open && sd_a[10]) begin
            bank_open[sd_ba] <= 1'b0;
          end
        end
        CMD_PRECHARGE: begin
          if (sd_a[10]) begin
            bank_open <= 4'b0000;
          end else begin
            bank_open[sd_ba] <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Word array write with per-byte masking; contents intentionally survive init.
  always_ff @(posedge clk) begin
    if (do_write) begin
      if (!sd_dqml) begin
        mem[idx][7:0] <= sd_dq_in[7:0];
      end
      if (!sd_dqmh) begin
        mem[idx][15:8] <= sd_dq_in[15:8];
      end
    end
  end

  // Read return pipeline and registered bus drive, sized by the current CAS latency.
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      pipe1_valid <= 1'b0;
      pipe1_cl3   <= 1'b0;
      pipe1_data  <= 16'h0000;
      pipe2_valid <= 1'b0;
      pipe2_data  <= 16'h0000;
      sd_dq_oe    <= 1'b0;
      sd_dq_out   <= 16'h0000;
    end else begin
      pipe1_valid <= do_read;
      pipe1_cl3   <= cl3;
      pipe1_data  <= rd_data;
      pipe2_valid <= pipe1_valid && pipe1_cl3;
      pipe2_data  <= pipe1_data;
      if (pipe1_valid && !pipe1_cl3) begin
        sd_dq_oe  <= 1'b1;
        sd_dq_out <= pipe1_data;
      end else if (pipe2_valid) begin
        sd_dq_oe  <= 1'b1;
        sd_dq_out <= pipe2_data;
      end else begin
        sd_dq_oe  <= 1'b0;
        sd_dq_out <= 16'h0000;
      end
    end
  end

  // Mode register, refresh counter and sticky error flags.
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      mode_reg    <= 13'h0000;
      mode_valid  <= 1'b0;
      refresh_cnt <= 16'h0000;
      err         <= 6'b000000;
    end else begin
      err <= err | err_set;
      case (cmd)
        CMD_REFRESH: begin
          refresh_cnt <= refresh_cnt + 16'd1;
        end
        CMD_LOAD_MODE: begin
          // The mode register is only touched when the device is idle.
          if (!mode_blocked) begin
            mode_reg   <= sd_a;
            mode_valid <= mode_legal;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_responder.sv
// tb_sdram_responder: directed scenarios plus randomized command streams, every cycle
// compared against a behavioural SDRAM model built from edge numbers, arrays and queues.
module tb_sdram_responder;

  localparam int TRCD = 2;

  logic        clk = 1'b0;
  logic        init = 1'b0;
  logic        sd_cke = 1'b1, sd_ncs = 1'b1, sd_nras = 1'b1, sd_ncas = 1'b1, sd_nwe = 1'b1;
  logic [1:0]  sd_ba = 2'd0;
  logic [12:0] sd_a = 13'd0;
  logic        sd_dqml = 1'b0, sd_dqmh = 1'b0;
  logic [15:0] sd_dq_in = 16'h0000;
  logic [15:0] sd_dq_out;
  logic        sd_dq_oe;
  logic [12:0] mode_reg;
  logic        mode_valid;
  logic [15:0] refresh_cnt;
  logic [5:0]  err;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int          e_cnt = 0;
  logic [15:0] m_mem [4096];
  logic [1:0]  m_kn  [4096];
  bit          m_open [4];
  int          m_row [4];
  int          m_act [4];
  logic [12:0] m_mode;
  bit          m_mv;
  logic [15:0] m_ref;
  logic [5:0]  m_err;
  int          rd_edge [$];
  int          rd_cl [$];
  logic [15:0] ret_data [int];
  logic [15:0] ret_msk [int];

  sdram_responder #(.ROW_W(5), .COL_W(5), .TRCD(TRCD)) dut (
    .clk(clk), .init(init), .sd_cke(sd_cke), .sd_ncs(sd_ncs), .sd_nras(sd_nras),
    .sd_ncas(sd_ncas), .sd_nwe(sd_nwe), .sd_ba(sd_ba), .sd_a(sd_a), .sd_dqml(sd_dqml),
    .sd_dqmh(sd_dqmh), .sd_dq_in(sd_dq_in), .sd_dq_out(sd_dq_out), .sd_dq_oe(sd_dq_oe),
    .mode_reg(mode_reg), .mode_valid(mode_valid), .refresh_cnt(refresh_cnt), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 4; b++) m_open[b] = 1'b0;
    m_mode = 13'h0; m_mv = 1'b0; m_ref = 16'h0; m_err = 6'h0;
    rd_edge.delete(); rd_cl.delete(); ret_data.delete(); ret_msk.delete();
  endtask

  // Apply one sampled command to the model; e is the number of the coming rising edge.
  task automatic model_edge(input bit cke, input bit ncs, input logic [2:0] c, input logic [1:0] ba,
                            input logic [12:0] a, input bit ml, input bit mh, input logic [15:0] dq);
    int e, idx, cl;
    bit pend, anyo;
    logic [15:0] d, k;
    e_cnt++;
    e = e_cnt;
    while (rd_edge.size() > 0 && rd_edge[0] + rd_cl[0] < e) begin
      void'(rd_edge.pop_front());
      void'(rd_cl.pop_front());
    end
    pend = 1'b0;
    foreach (rd_edge[i]) if (rd_edge[i] < e && e <= rd_edge[i] + rd_cl[i] - 1) pend = 1'b1;
    anyo = m_open[0] || m_open[1] || m_open[2] || m_open[3];
    if (!cke || ncs) return;
    idx = int'(ba) * 1024 + m_row[ba] * 32 + int'(a[4:0]);
    case (c)
      3'b011: begin
        if (m_open[ba]) m_err[0] = 1'b1;
        else begin m_open[ba] = 1'b1; m_row[ba] = int'(a[4:0]); m_act[ba] = e; end
      end
      3'b100, 3'b101: begin
        if (!m_mv) m_err[5] = 1'b1;
        if (c == 3'b100 && pend) m_err[3] = 1'b1;
        if (!m_open[ba]) m_err[1] = 1'b1;
        else begin
          if (e - m_act[ba] < TRCD) m_err[2] = 1'b1;
          if (c == 3'b100) begin
            if (!ml) begin m_mem[idx][7:0] = dq[7:0]; m_kn[idx][0] = 1'b1; end
            if (!mh) begin m_mem[idx][15:8] = dq[15:8]; m_kn[idx][1] = 1'b1; end
          end else begin
            cl = (m_mode[6:4] == 3'd3) ? 3 : 2;
            d = m_mem[idx];
            k = {{8{m_kn[idx][1]}}, {8{m_kn[idx][0]}}};
            if (ml) begin d[7:0] = 8'h00; k[7:0] = 8'hFF; end
            if (mh) begin d[15:8] = 8'h00; k[15:8] = 8'hFF; end
            rd_edge.push_back(e);
            rd_cl.push_back(cl);
            ret_data[e + cl - 1] = d;
            ret_msk[e + cl - 1] = k;
          end
          if (a[10]) m_open[ba] = 1'b0;
        end
      end
      3'b010: begin
        if (a[10]) for (int b = 0; b < 4; b++) m_open[b] = 1'b0;
        else m_open[ba] = 1'b0;
      end
      3'b001: begin
        m_ref = m_ref + 16'd1;
        if (anyo) m_err[4] = 1'b1;
      end
      3'b000: begin
        if (anyo || pend) m_err[4] = 1'b1;
        else begin
          m_mode = a;
          m_mv = 1'b1;
          if (!(a[6:4] == 3'd2 || a[6:4] == 3'd3) || a[2:0] != 3'd0) begin
            m_err[5] = 1'b1;
            m_mv = 1'b0;
          end
        end
      end
      default: begin end
    endcase
  endtask

  task automatic compare_all();
    bit has;
    logic [15:0] ed, em;
    has = ret_data.exists(e_cnt);
    ed = 16'h0000;
    em = 16'hFFFF;
    if (has) begin ed = ret_data[e_cnt]; em = ret_msk[e_cnt]; end
    check_val("oe", 32'(sd_dq_oe), 32'(has));
    check_val("dq", 32'(sd_dq_out & em), 32'(ed & em));
    check_val("err", 32'(err), 32'(m_err));
    check_val("mode", 32'({mode_valid, mode_reg}), 32'({m_mv, m_mode}));
    check_val("rcnt", 32'(refresh_cnt), 32'(m_ref));
  endtask

  task automatic drive(input bit cke, input bit ncs, input logic [2:0] c, input logic [1:0] ba,
                       input logic [12:0] a, input bit ml, input bit mh, input logic [15:0] dq);
    @(negedge clk);
    sd_cke = cke; sd_ncs = ncs; {sd_nras, sd_ncas, sd_nwe} = c;
    sd_ba = ba; sd_a = a; sd_dqml = ml; sd_dqmh = mh; sd_dq_in = dq;
    model_edge(cke, ncs, c, ba, a, ml, mh, dq);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 3'b111, 2'd0, 13'd0, 1'b0, 1'b0, 16'h0);
  endtask
  task automatic lmr(input logic [12:0] v);
    drive(1'b1, 1'b0, 3'b000, 2'd0, v, 1'b0, 1'b0, 16'h0);
  endtask
  task automatic act(input logic [1:0] ba, input logic [12:0] row);
    drive(1'b1, 1'b0, 3'b011, ba, row, 1'b0, 1'b0, 16'h0);
  endtask
  task automatic wr(input logic [1:0] ba, input logic [12:0] a, input logic [15:0] dq, input bit ml, input bit mh);
    drive(1'b1, 1'b0, 3'b100, ba, a, ml, mh, dq);
  endtask
  task automatic rd(input logic [1:0] ba, input logic [12:0] a, input bit ml, input bit mh);
    drive(1'b1, 1'b0, 3'b101, ba, a, ml, mh, 16'h0);
  endtask
  task automatic pre(input logic [1:0] ba, input bit all);
    drive(1'b1, 1'b0, 3'b010, ba, {2'b00, all, 10'd0}, 1'b0, 1'b0, 16'h0);
  endtask
  task automatic refr();
    drive(1'b1, 1'b0, 3'b001, 2'd0, 13'd0, 1'b0, 1'b0, 16'h0);
  endtask

  // Asynchronous init in mid-cycle: outputs must fall before the next clock edge.
  task automatic do_reset();
    @(negedge clk);
    sd_cke = 1'b1; sd_ncs = 1'b1; {sd_nras, sd_ncas, sd_nwe} = 3'b111;
    #2 init = 1'b1;
    #1;
    check_val("rst_oe", 32'(sd_dq_oe), 32'd0);
    check_val("rst_dq", 32'(sd_dq_out), 32'd0);
    check_val("rst_err", 32'(err), 32'd0);
    check_val("rst_mode", 32'({mode_valid, mode_reg}), 32'd0);
    check_val("rst_rcnt", 32'(refresh_cnt), 32'd0);
    model_reset();
    @(negedge clk);
    init = 1'b0;
  endtask

  initial begin
    int r;
    logic [12:0] a;
    for (int i = 0; i < 4096; i++) m_kn[i] = 2'b00;
    for (int b = 0; b < 4; b++) begin m_row[b] = 0; m_act[b] = 0; end
    model_reset();

    // Basic write/read at CL2 with byte masks.
    do_reset();
    lmr(13'h220);
    act(2'd1, 13'd3);
    nop(1);
    wr(2'd1, 13'd4, 16'hBEEF, 1'b0, 1'b0);
    rd(2'd1, 13'd4, 1'b0, 1'b0);
    nop(1);
    check_val("beef_oe", 32'(sd_dq_oe), 32'd1);
    check_val("beef_dq", 32'(sd_dq_out), 32'hBEEF);
    nop(1);
    check_val("beef_oe_off", 32'(sd_dq_oe), 32'd0);
    check_val("beef_err", 32'(err), 32'd0);
    wr(2'd1, 13'd4, 16'h1234, 1'b0, 1'b1);
    rd(2'd1, 13'd4, 1'b0, 1'b0);
    nop(1);
    check_val("dqmh_dq", 32'(sd_dq_out), 32'hBE34);
    nop(2);
    rd(2'd1, 13'd4, 1'b1, 1'b0);
    nop(1);
    check_val("dqml_dq", 32'(sd_dq_out), 32'hBE00);
    nop(2);
    act(2'd0, 13'd7);
    rd(2'd0, 13'd0, 1'b0, 1'b0);
    nop(2);
    check_val("trcd_err2", 32'(err[2]), 32'd1);
    rd(2'd2, 13'd0, 1'b0, 1'b0);
    check_val("closed_err1", 32'(err[1]), 32'd1);
    nop(2);

    // Auto-precharge, refresh counting and refresh with an open bank.
    do_reset();
    lmr(13'h220);
    act(2'd1, 13'd3);
    nop(1);
    wr(2'd1, 13'h405, 16'h5A5A, 1'b0, 1'b0);
    rd(2'd1, 13'd5, 1'b0, 1'b0);
    check_val("ap_err1", 32'(err[1]), 32'd1);
    pre(2'd0, 1'b1);
    refr(); refr(); refr();
    check_val("ref3", 32'(refresh_cnt), 32'd3);
    check_val("ref_err4", 32'(err[4]), 32'd0);
    act(2'd0, 13'd1);
    refr();
    check_val("ref_open_err4", 32'(err[4]), 32'd1);

    // CL3 latency and illegal mode.
    do_reset();
    lmr(13'h230);
    act(2'd1, 13'd3);
    nop(1);
    rd(2'd1, 13'd4, 1'b0, 1'b0);
    nop(1);
    check_val("cl3_early", 32'(sd_dq_oe), 32'd0);
    nop(1);
    check_val("cl3_dq", 32'(sd_dq_out), 32'hBE34);
    nop(1);
    pre(2'd0, 1'b1);
    lmr(13'h201);
    check_val("lmr201_mv", 32'(mode_valid), 32'd0);
    check_val("lmr201_err5", 32'(err[5]), 32'd1);

    // Back-to-back reads, init mid-stream, data intact afterwards.
    do_reset();
    lmr(13'h220);
    act(2'd3, 13'd0);
    nop(1);
    for (int i = 0; i < 4; i++) wr(2'd3, 13'(i), 16'h1000 + 16'(i * 17), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) rd(2'd3, 13'(i), 1'b0, 1'b0);
    do_reset();
    lmr(13'h220);
    act(2'd3, 13'd0);
    nop(1);
    for (int i = 0; i < 4; i++) rd(2'd3, 13'(i), 1'b0, 1'b0);
    nop(4);

    // Randomized command streams.
    for (int seg = 0; seg < 6; seg++) begin
      do_reset();
      lmr(13'h200 | 13'(($urandom_range(0, 1) + 2) << 4));
      for (int n = 0; n < 150; n++) begin
        r = $urandom_range(0, 99);
        a = 13'($urandom_range(0, 7)) | (($urandom_range(0, 9) == 0) ? 13'h400 : 13'h000)
            | 13'($urandom_range(0, 1) << 11);
        if (r < 15) act(2'($urandom_range(0, 3)), 13'($urandom_range(0, 3)) | 13'($urandom_range(0, 1) << 7));
        else if (r < 40) wr(2'($urandom_range(0, 3)), a, 16'($urandom),
                            $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
        else if (r < 65) rd(2'($urandom_range(0, 3)), a, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
        else if (r < 72) pre(2'($urandom_range(0, 3)), $urandom_range(0, 2) == 0);
        else if (r < 75) refr();
        else if (r < 78) lmr(13'h200 | 13'($urandom_range(0, 7) << 4) | 13'($urandom_range(0, 3) == 0));
        else if (r < 82) drive(1'b0, 1'b0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), a, 1'b0, 1'b0, 16'($urandom));
        else if (r < 85) drive(1'b1, 1'b1, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), a, 1'b0, 1'b0, 16'($urandom));
        else nop(1);
      end
      nop(4);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
